in_port_ctrl: RTL

//   Producer side of the CPU input-port handshake. Synchronises the slide switches and a "ready" push-button,

---
 rtl/io_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 36 +++
 rtl/in_port_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared types and constants for the board-side input-port logic.
package io_pkg;

    // Button debounce states
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } btn_state_t;

    // Flop count of every pin synchroniser
    localparam int SYNC_STAGES = 2;

    // Map a raw button level to "1 = pressed"
    function automatic logic btn_pressed(input logic lvl, input bit active_low);
        return active_low ? ~lvl : lvl;
    endfunction

endpackage : io_pkg

// File: rtl/sync_2ff.sv
// Multi-flop synchroniser for asynchronous board inputs. Each bit is
// sampled independently, so multi-bit buses are only coherent once the
// source has been stable for a few cycles.
module sync_2ff
    import io_pkg::*;
#(
    parameter int             W         = 1,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_reg [SYNC_STAGES];

    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            // First stage captures the asynchronous pin level
            always_ff @(posedge clk or negedge n_reset) begin
                if (!n_reset) stage_reg[gi] <= RESET_VAL;
                else          stage_reg[gi] <= d;
            end
        end else begin : g_next
            // Later stages give metastability time to resolve
            always_ff @(posedge clk or negedge n_reset) begin
                if (!n_reset) stage_reg[gi] <= RESET_VAL;
                else          stage_reg[gi] <= stage_reg[gi-1];
            end
        end
    end

    assign q = stage_reg[SYNC_STAGES-1];

endmodule : sync_2ff

// File: rtl/in_port_ctrl.sv
// Producer side of the CPU input-port handshake: synchronises the
// switches and the ready button, debounces the button, snapshots the
// switches once per clean press and holds ready_out until the CPU acks.
module in_port_ctrl #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             btn_raw,
    input  logic             ack,
    output logic [WIDTH-1:0] data_out,
    output logic             ready_out,
    output logic             overrun
);

    import io_pkg::*;

    localparam int              CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT     = '1;
    localparam bit               ONE_SAMPLE  = (DEBOUNCE_CYCLES == 1);
    localparam bit               ACTIVE_LOW  = (BTN_ACTIVE_LOW != 0);
    // Synchroniser resets to the released level so a button held through
    // reset is seen as a new press once reset lifts.
    localparam logic [0:0]       BTN_REL_LVL = ACTIVE_LOW ? 1'b1 : 1'b0;

    logic [WIDTH-1:0] sw_s;
    logic [0:0]       btn_sync;
    logic             btn_s;

    btn_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             do_latch;

    logic [WIDTH-1:0] data_reg;
    logic             ready_reg;
    logic             overrun_reg;

    sync_2ff #(
        .W         (WIDTH),
        .RESET_VAL ({WIDTH{1'b0}})
    ) u_sw_sync (
        .clk     (clk),
        .n_reset (n_reset),
        .d       (sw_raw),
        .q       (sw_s)
    );

    sync_2ff #(
        .W         (1),
        .RESET_VAL (BTN_REL_LVL)
    ) u_btn_sync (
        .clk     (clk),
        .n_reset (n_reset),
        .d       (btn_raw),
        .q       (btn_sync)
    );

    assign btn_s = btn_pressed(btn_sync[0], ACTIVE_LOW);

    // Debounce state and sample counter registers
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg <= IDLE;
            cnt_reg   <= CNT_ZERO;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Debounce next-state: a press or release must be seen for
    // DEBOUNCE_CYCLES consecutive samples; the snapshot strobe fires once
    // on the transition into PRESSED only.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        do_latch   = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (btn_s) begin
                    if (ONE_SAMPLE) begin
                        state_next = PRESSED;
                        cnt_next   = CNT_ZERO;
                        do_latch   = 1'b1;
                    end else begin
                        state_next = DEB_PRESS;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            DEB_PRESS: begin
                if (!btn_s) begin
                    state_next = IDLE;
                    cnt_next   = CNT_ZERO;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = CNT_ZERO;
                    do_latch   = 1'b1;
                end else if (cnt_reg != CNT_SAT) begin
                    cnt_next   = cnt_reg + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    if (ONE_SAMPLE) begin
                        state_next = IDLE;
                        cnt_next   = CNT_ZERO;
                    end else begin
                        state_next = DEB_RELEASE;
                        cnt_next   = CNT_ONE;
                    end
                end
            end
            DEB_RELEASE: begin
                if (btn_s) begin
                    // Release bounce: back to held, no second snapshot
                    state_next = PRESSED;
                    cnt_next   = CNT_ZERO;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = CNT_ZERO;
                end else if (cnt_reg != CNT_SAT) begin
                    cnt_next   = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = CNT_ZERO;
            end
        endcase
    end

    // Snapshot / ready / overrun handshake. A new snapshot always wins over
    // an ack on the same edge; an ack on that edge consumes the old value,
    // so no overrun is flagged.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            data_reg    <= '0;
            ready_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else if (do_latch) begin
            data_reg  <= sw_s;
            ready_reg <= 1'b1;
            if (ready_reg) overrun_reg <= !ack;
        end else if (ack && ready_reg) begin
            ready_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end
    end

    assign data_out  = data_reg;
    assign ready_out = ready_reg;
    assign overrun   = overrun_reg;

endmodule : in_port_ctrl
